pixel_ram_arbiter: RTL and testbench
====================================

Name: pixel_ram_arbiter

Overview:
- Owns port A of the dual-port pixel RAM (the 17-bit-address, 32-bit-data frame store). Port B stays dedicated to the VGA scan-out.
- Shares port A between two requesters: m0 is the processor load/store path and m1 is the image loader/DMA.
- Uses a round-robin arbiter with burst ownership, a beat cap, and tagged read-return routing.
- Drives address_a, data_a, wren_a, rden_a and byteena_a from registers, and returns q_a to the requester that issued each read.

Parameters:
- ADDR_W, 17, RAM word-address width
- DATA_W, 32, RAM data width
- BE_W, 4, byte-enable width (DATA_W/8)
- RD_LAT, 2, cycles from rden_a asserted at the RAM to q_a valid
- MAX_BURST, 16, maximum beats per ownership before forced release

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_req/m1_req  in  1  beat request
- m0_we/m1_we  in  1  1 = write, 0 = read
- m0_addr/m1_addr  in  ADDR_W  word address
- m0_wdata/m1_wdata  in  DATA_W  write data
- m0_be/m1_be  in  BE_W  write byte enables
- m0_last/m1_last  in  1  final beat of the burst
- m0_gnt/m1_gnt  out  1  beat accepted this cycle when req&gnt
- m0_rvalid/m1_rvalid  out  1  read data valid
- m0_rdata/m1_rdata  out  DATA_W  read data
- address_a  out  ADDR_W  RAM port A address
- data_a  out  DATA_W  RAM port A write data
- wren_a  out  1  RAM port A write enable
- rden_a  out  1  RAM port A read enable
- byteena_a  out  BE_W  RAM port A byte enables
- q_a  in  DATA_W  RAM port A read data

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset effects:
  - state=IDLE, rr_ptr=m0, beat_cnt=0.
  - address_a=0, data_a=0, wren_a=0, rden_a=0, byteena_a=0.
  - Tag pipeline cleared. In-flight reads are discarded, so no rvalid is produced after reset.
  - gnt and rvalid are 0.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - gnt goes combinationally to the single requester, or to rr_ptr's side when both request.
  - The accepted beat moves state to OWNx.
  - If that first beat has last=1 and MAX_BURST=1 semantics apply, it ends ownership immediately (see release).
- OWNx:
  - mx_gnt=1 and the other gnt=0 for every cycle of the burst.
  - Each cycle with mx_req=1 is one accepted beat, and beat_cnt increments.
- Release condition, any of the following:
  - an accepted beat with last=1;
  - an accepted beat that makes beat_cnt==MAX_BURST;
  - mx_req=0 while in OWNx (abandoned burst).
- On release:
  - rr_ptr points to the other requester and beat_cnt clears.
  - Next state is OWNother if the other requester's req=1 in the release cycle, otherwise IDLE.
  - No idle bubble is inserted when switching owners.
- RAM side (one-cycle registered issue):
  - A beat accepted in cycle N drives port A in cycle N+1.
  - Write beat: address_a=addr, data_a=wdata, byteena_a=be, wren_a=1, rden_a=0.
  - Read beat: address_a=addr, byteena_a=all ones, rden_a=1, wren_a=0, data_a unchanged.
  - Cycles with no accepted beat: wren_a=rden_a=0, address_a/data_a/byteena_a hold their values.
- Read return:
  - A tag {valid, owner} is shifted through a delay of RD_LAT+1 stages.
  - A read accepted in cycle N gives mx_rvalid=1 in cycle N+1+RD_LAT, with mx_rdata=q_a (combinational pass-through).
  - The other requester's rvalid stays 0 and its rdata also shows q_a; it is don't-care.
  - Reads are returned in issue order. Back-to-back reads give back-to-back rvalid with no loss.
- Hazards:
  - A write then a read to the same address are serviced in acceptance order; the RAM port handles them sequentially.
  - The arbiter never reorders beats.
- Throughput is 1 beat per cycle sustained, including across an owner switch.

Decomposition:
- Package pisa_mem_pkg holds:
  - ADDR_W, DATA_W, BE_W, RD_LAT;
  - the owner_e enum {OWN_NONE, OWN_M0, OWN_M1};
  - arb_state_e {IDLE, OWN0, OWN1};
  - the rd_tag_t struct {valid, owner}.
- One sub-module, rd_tag_pipe: a parameterised RD_LAT+1-stage shift register of rd_tag_t with synchronous clear.

Test Plan:
- Single read: m0 reads 0x00010 with RAM preloaded to 0xDEADBEEF.
  - m0_gnt=1 at cycle 0, rden_a=1 with address_a=0x00010 at cycle 1.
  - m0_rvalid=1 and m0_rdata=0xDEADBEEF at cycle 3; m1_rvalid stays 0.
- Contention after reset: m0 and m1 both request a 1-beat write with last=1.
  - m0 wins; m1 is granted the next cycle with no bubble.
  - wren_a is high for 2 consecutive cycles with addresses m0 then m1.
- Burst cap: m1 holds a 20-beat read burst with no last and MAX_BURST=16, while m0 is also requesting.
  - m1 is released after 16 beats and m0 is granted at beat 17.
  - m1 regains the grant after m0's last beat.
  - All 20 m1 rvalids arrive in order.
- Byte-enable write: m0 writes 0x11223344 with be=0011 to 0x1FFFF (the maximum address).
  - byteena_a=0011 and address_a=0x1FFFF.
  - A readback of a cell previously 0xAABBCCDD returns 0xAABB3344.
- Abandoned burst: m0 drops req after 3 beats without last.
  - State goes to IDLE, then m1 is granted.
  - rr_ptr points to m1, so when both request again m1 wins.
- Reset mid-read: assert reset 1 cycle after a read is accepted.
  - No rvalid on either port afterwards.
  - All RAM outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/pisa_mem_pkg.sv
// Shared types and sizes for the pixel RAM port-A arbiter.
package pisa_mem_pkg;
   localparam int ADDR_W = 17;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;
   localparam int RD_LAT = 2;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_M0   = 2'd1,
      OWN_M1   = 2'd2
   } owner_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rd_tag_t;
endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line carrying the read-return tag alongside the RAM read latency.
module rd_tag_pipe
   import pisa_mem_pkg::*;
#(
   parameter int STAGES = RD_LAT + 1
) (
   input  logic    clk,
   input  logic    clr,
   input  rd_tag_t tag_in,
   output rd_tag_t tag_out
);
   rd_tag_t [STAGES:1] tag_pipe;

   // shift one stage per cycle; clr drops every in-flight tag
   always_ff @(posedge clk) begin
      if (clr) begin
         tag_pipe <= '0;
      end else begin
         tag_pipe[1] <= tag_in;
         for (int k = 2; k <= STAGES; k++) tag_pipe[k] <= tag_pipe[k-1];
      end
   end

   assign tag_out = tag_pipe[STAGES];
endmodule

// File: rtl/pixel_ram_arbiter.sv
// Port-A owner of the pixel frame store: round-robin burst arbitration
// between the CPU path (m0) and the image loader (m1), registered RAM
// issue and tagged read-return routing.
module pixel_ram_arbiter
   import pisa_mem_pkg::*;
#(
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [BE_W-1:0]   m0_be,
   input  logic              m0_last,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [BE_W-1:0]   m1_be,
   input  logic              m1_last,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] address_a,
   output logic [DATA_W-1:0] data_a,
   output logic              wren_a,
   output logic              rden_a,
   output logic [BE_W-1:0]   byteena_a,
   input  logic [DATA_W-1:0] q_a
);
   localparam int               CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CAP   = CNT_W'(MAX_BURST);

   arb_state_e        state, state_nxt;
   owner_e            rr_ptr, rr_nxt;
   logic [CNT_W-1:0]  beat_cnt, cnt_nxt, cnt_inc;
   logic              acc, rel;
   logic              b_we, b_last;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic [BE_W-1:0]   b_be;
   rd_tag_t           tag_in, tag_out;

   // arbitration state, round-robin pointer and burst beat counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= OWN_M0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         beat_cnt <= cnt_nxt;
      end
   end

   // grant: combinational pick in IDLE, owner held for the whole burst
   always_comb begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      unique case (state)
         IDLE: begin
            if (m0_req && m1_req) begin
               if (rr_ptr == OWN_M1) m1_gnt = 1'b1;
               else                  m0_gnt = 1'b1;
            end else begin
               m0_gnt = m0_req;
               m1_gnt = m1_req;
            end
         end
         OWN0:    m0_gnt = 1'b1;
         OWN1:    m1_gnt = 1'b1;
         default: ;
      endcase
   end

   // the granted side's beat, muxed toward the RAM issue registers
   assign acc     = (m0_gnt & m0_req) | (m1_gnt & m1_req);
   assign b_we    = m1_gnt ? m1_we    : m0_we;
   assign b_last  = m1_gnt ? m1_last  : m0_last;
   assign b_addr  = m1_gnt ? m1_addr  : m0_addr;
   assign b_wdata = m1_gnt ? m1_wdata : m0_wdata;
   assign b_be    = m1_gnt ? m1_be    : m0_be;
   assign cnt_inc = beat_cnt + CNT_W'(1);

   // next state: release on last, beat cap or a dropped request, and hand
   // straight to the other side if it is already waiting (no idle bubble)
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      cnt_nxt   = beat_cnt;
      rel       = 1'b0;
      if (acc) begin
         cnt_nxt   = cnt_inc;
         rel       = b_last || (cnt_inc == CAP);
         state_nxt = m1_gnt ? OWN1 : OWN0;
      end else if (state != IDLE) begin
         rel = 1'b1;
      end
      if (rel) begin
         cnt_nxt = '0;
         if (m1_gnt) begin
            rr_nxt    = OWN_M0;
            state_nxt = m0_req ? OWN0 : IDLE;
         end else begin
            rr_nxt    = OWN_M1;
            state_nxt = m1_req ? OWN1 : IDLE;
         end
      end
   end

   // registered port-A issue; address/data/byteena hold on idle cycles
   always_ff @(posedge clk) begin
      if (reset) begin
         address_a <= '0;
         data_a    <= '0;
         byteena_a <= '0;
         wren_a    <= 1'b0;
         rden_a    <= 1'b0;
      end else begin
         wren_a <= acc & b_we;
         rden_a <= acc & ~b_we;
         if (acc) begin
            address_a <= b_addr;
            if (b_we) begin
               data_a    <= b_wdata;
               byteena_a <= b_be;
            end else begin
               byteena_a <= '1;
            end
         end
      end
   end

   // tag each accepted read with its issuer; it emerges as q_a lands
   always_comb begin
      tag_in.valid = acc & ~b_we;
      tag_in.owner = m1_gnt ? OWN_M1 : OWN_M0;
   end

   rd_tag_pipe #(.STAGES(RD_LAT + 1)) u_tag_pipe (
      .clk     (clk),
      .clr     (reset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign m0_rvalid = tag_out.valid && (tag_out.owner == OWN_M0);
   assign m1_rvalid = tag_out.valid && (tag_out.owner == OWN_M1);
   assign m0_rdata  = q_a;
   assign m1_rdata  = q_a;
endmodule

// File: tb/tb_pixel_ram_arbiter.sv
// Directed bench for pixel_ram_arbiter with a 2-cycle-latency RAM model.
module tb_pixel_ram_arbiter;
   import pisa_mem_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              m0_req, m0_we, m0_last, m0_gnt, m0_rvalid;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata, m0_rdata;
   logic [BE_W-1:0]   m0_be;
   logic              m1_req, m1_we, m1_last, m1_gnt, m1_rvalid;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata, m1_rdata;
   logic [BE_W-1:0]   m1_be;
   logic [ADDR_W-1:0] address_a;
   logic [DATA_W-1:0] data_a, q_a;
   logic              wren_a, rden_a;
   logic [BE_W-1:0]   byteena_a;

   int errs   = 0;
   int checks = 0;

   // preload port into the RAM model
   logic              pl_en;
   logic [ADDR_W-1:0] pl_addr;
   logic [DATA_W-1:0] pl_data;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rd1, q_r;
   logic [DATA_W-1:0] r0_q[$];
   logic [DATA_W-1:0] r1_q[$];

   always #5 clk = ~clk;

   pixel_ram_arbiter #(.MAX_BURST(16)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_be(m0_be), .m0_last(m0_last), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_be(m1_be), .m1_last(m1_last), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_rdata(m1_rdata),
      .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
      .byteena_a(byteena_a), .q_a(q_a)
   );

   // RAM model: byte-masked write, read data two cycles after rden_a
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (wren_a)
         for (int b = 0; b < BE_W; b++)
            if (byteena_a[b]) mem[address_a][8*b +: 8] <= data_a[8*b +: 8];
      if (rden_a) rd1 <= mem[address_a];
      q_r <= rd1;
   end
   assign q_a = q_r;

   // collect returned read data per requester
   always @(negedge clk) begin
      if (m0_rvalid === 1'b1) r0_q.push_back(m0_rdata);
      if (m1_rvalid === 1'b1) r1_q.push_back(m1_rdata);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0; m0_last = 0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0; m1_last = 0;
   endtask

   task automatic do_reset();
      reset = 1; idle();
      step();
      reset = 0;
   endtask

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      pl_en = 1; pl_addr = a; pl_data = d;
      step();
      pl_en = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b1, m0_cyc, m1_before, m1_after, base0, base1;
      bit m0_done;
      reset = 1; pl_en = 0; pl_addr = '0; pl_data = '0; idle();
      step();
      preload(17'h00010, 32'hDEADBEEF);
      preload(17'h00200, 32'h0BADF00D);
      preload(17'h1FFFF, 32'hAABBCCDD);
      for (int i = 0; i < 20; i++) preload(17'(256 + i), 32'hC0DE0000 + 32'(i));
      reset = 0;
      settle();
      // reset state
      chk("rst address_a", 32'(address_a), 32'd0);
      chk("rst data_a",    data_a, 32'd0);
      chk("rst byteena_a", 32'(byteena_a), 32'd0);
      chk("rst wren_a",    32'(wren_a), 32'd0);
      chk("rst rden_a",    32'(rden_a), 32'd0);
      chk("rst gnt",       32'({m1_gnt, m0_gnt}), 32'd0);
      chk("rst rvalid",    32'({m1_rvalid, m0_rvalid}), 32'd0);

      // single read by m0
      m0_req = 1; m0_we = 0; m0_addr = 17'h00010; m0_last = 1;
      settle();
      chk("rd m0_gnt", 32'(m0_gnt), 32'd1);
      chk("rd m1_gnt", 32'(m1_gnt), 32'd0);
      step(); idle(); settle();
      chk("rd rden_a",    32'(rden_a), 32'd1);
      chk("rd wren_a",    32'(wren_a), 32'd0);
      chk("rd address_a", 32'(address_a), 32'h10);
      chk("rd byteena_a", 32'(byteena_a), 32'hF);
      step(); settle();
      chk("rd early rvalid", 32'(m0_rvalid), 32'd0);
      step(); settle();
      chk("rd m0_rvalid", 32'(m0_rvalid), 32'd1);
      chk("rd m0_rdata",  m0_rdata, 32'hDEADBEEF);
      chk("rd m1_rvalid", 32'(m1_rvalid), 32'd0);
      step();

      // contention right after reset: m0 first, m1 next cycle
      do_reset();
      m0_req = 1; m0_we = 1; m0_addr = 17'h20; m0_wdata = 32'h0A0A0A0A; m0_be = 4'hF; m0_last = 1;
      m1_req = 1; m1_we = 1; m1_addr = 17'h21; m1_wdata = 32'h1B1B1B1B; m1_be = 4'hF; m1_last = 1;
      settle();
      chk("ct m0_gnt c0", 32'(m0_gnt), 32'd1);
      chk("ct m1_gnt c0", 32'(m1_gnt), 32'd0);
      step(); m0_req = 0; settle();
      chk("ct m1_gnt c1", 32'(m1_gnt), 32'd1);
      chk("ct m0_gnt c1", 32'(m0_gnt), 32'd0);
      chk("ct wren c1",   32'(wren_a), 32'd1);
      chk("ct addr c1",   32'(address_a), 32'h20);
      chk("ct data c1",   data_a, 32'h0A0A0A0A);
      step(); m1_req = 0; settle();
      chk("ct wren c2",   32'(wren_a), 32'd1);
      chk("ct addr c2",   32'(address_a), 32'h21);
      chk("ct data c2",   data_a, 32'h1B1B1B1B);
      step(); settle();
      chk("ct wren c3",   32'(wren_a), 32'd0);

      // burst cap: m1 20-beat read, m0 waiting from cycle 1
      base0 = r0_q.size(); base1 = r1_q.size();
      b1 = 0; m0_done = 0; m0_cyc = -1; m1_before = 0; m1_after = -1;
      idle();
      for (int c = 0; c < 40 && (b1 < 20 || !m0_done); c++) begin
         m1_req = (b1 < 20); m1_we = 0; m1_addr = 17'(256 + b1); m1_last = (b1 == 19);
         m0_req = (c >= 1) && !m0_done; m0_we = 0; m0_addr = 17'h00200; m0_last = 1;
         settle();
         if (m0_gnt && m0_req) begin m0_done = 1; m0_cyc = c; end
         if (m1_gnt && m1_req) begin
            if (!m0_done) m1_before++;
            else if (m1_after < 0) m1_after = c;
            b1++;
         end
         step();
      end
      idle();
      chk("cap m1 beats before release", 32'(m1_before), 32'd16);
      chk("cap m0 grant cycle",          32'(m0_cyc), 32'd16);
      chk("cap m1 regain cycle",         32'(m1_after), 32'd17);
      chk("cap m1 total beats",          32'(b1), 32'd20);
      repeat (6) step();
      chk("cap m1 rvalid count", 32'(r1_q.size() - base1), 32'd20);
      for (int i = 0; i < 20; i++)
         if (base1 + i < r1_q.size())
            chk($sformatf("cap m1 rdata[%0d]", i), r1_q[base1 + i], 32'hC0DE0000 + 32'(i));
      chk("cap m0 rvalid count", 32'(r0_q.size() - base0), 32'd1);
      if (base0 < r0_q.size()) chk("cap m0 rdata", r0_q[base0], 32'h0BADF00D);

      // byte-enable write at the top address, then read back
      m0_req = 1; m0_we = 1; m0_addr = 17'h1FFFF; m0_wdata = 32'h11223344; m0_be = 4'b0011; m0_last = 1;
      settle();
      chk("be m0_gnt", 32'(m0_gnt), 32'd1);
      step();
      m0_we = 0; m0_be = 4'b0000;
      settle();
      chk("be wren_a",    32'(wren_a), 32'd1);
      chk("be byteena_a", 32'(byteena_a), 32'h3);
      chk("be address_a", 32'(address_a), 32'h1FFFF);
      chk("be data_a",    data_a, 32'h11223344);
      chk("be rd m0_gnt", 32'(m0_gnt), 32'd1);
      step(); idle(); settle();
      chk("be rd rden_a", 32'(rden_a), 32'd1);
      chk("be rd data_a held", data_a, 32'h11223344);
      step(); step(); settle();
      chk("be rd rvalid", 32'(m0_rvalid), 32'd1);
      chk("be rd rdata",  m0_rdata, 32'hAABB3344);
      step();

      // abandoned burst flips the round-robin pointer
      do_reset();
      for (int i = 0; i < 3; i++) begin
         m0_req = 1; m0_we = 1; m0_addr = 17'(768 + i); m0_wdata = 32'(i); m0_be = 4'hF; m0_last = 0;
         settle();
         chk($sformatf("ab m0_gnt beat%0d", i), 32'(m0_gnt), 32'd1);
         step();
      end
      m0_req = 0; settle();
      chk("ab m1_gnt at drop", 32'(m1_gnt), 32'd0);
      step();
      m0_req = 1; m0_we = 1; m0_addr = 17'h320; m0_wdata = 32'h5; m0_be = 4'hF; m0_last = 1;
      m1_req = 1; m1_we = 1; m1_addr = 17'h310; m1_wdata = 32'h6; m1_be = 4'hF; m1_last = 1;
      settle();
      chk("ab m1 wins", 32'(m1_gnt), 32'd1);
      chk("ab m0 loses", 32'(m0_gnt), 32'd0);
      step(); m1_req = 0; settle();
      chk("ab m0 next", 32'(m0_gnt), 32'd1);
      chk("ab addr m1 write", 32'(address_a), 32'h310);
      step(); idle(); step();

      // reset one cycle after a read is accepted
      m0_req = 1; m0_we = 0; m0_addr = 17'h00010; m0_last = 1;
      settle();
      chk("mr m0_gnt", 32'(m0_gnt), 32'd1);
      step(); idle(); reset = 1;
      step(); reset = 0; settle();
      base0 = r0_q.size(); base1 = r1_q.size();
      chk("mr address_a", 32'(address_a), 32'd0);
      chk("mr data_a",    data_a, 32'd0);
      chk("mr byteena_a", 32'(byteena_a), 32'd0);
      chk("mr wren_a",    32'(wren_a), 32'd0);
      chk("mr rden_a",    32'(rden_a), 32'd0);
      repeat (6) step();
      chk("mr no m0 rvalid", 32'(r0_q.size() - base0), 32'd0);
      chk("mr no m1 rvalid", 32'(r1_q.size() - base1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
